reg_control: RTL and testbench
==============================

// Module: reg_control
// PURPOSE
//  Register control unit in front of the register file. Accepts one register op at a time
//  over a valid/ready handshake. Maps logical register IDs to physical select lines via the
//  alternate-bank flags (AF/AF', EXX, per-bank DE<->HL swap). Drives the file's GP and system
//  select / oe / we lines with a registered state machine.
// PARAMETERS
//  none (register IDs, ops and physical indices are constants in reg_ctl_pkg)
// PORTS
//  clk            in   1   CPU clock; all state changes on its rising edge
//  reset          in   1   synchronous, active-high reset
//  req_valid      in   1   op request valid
//  req_ready      out  1   block idle, accepts op this cycle
//  req_op         in   3   0 NOP,1 READ,2 WRITE,3 XFER,4 EX_AF,5 EXX,6 EX_DEHL,7 rsvd(=NOP)
//  req_src        in   4   logical src id: 0 BC,1 DE,2 HL,3 AF,4 SP,5 IX,6 IY,7 WZ,8 PC,9 IR
//  req_dst        in   4   logical dst id (same encoding); 10-15 invalid
//  req_hi/req_lo  in   1   byte enables (high/low byte) for the access
//  done           out  1   1-cycle pulse in final cycle of an accepted op
//  err            out  1   1-cycle pulse with done when op had an invalid id / empty byte mask
//  reg_sel_gp     out  12  one-hot physical GP select: af,af2,bc,bc2,de,de2,hl,hl2,ix,iy,wz,sp
//  reg_sel_gp_hi/lo out 1  GP byte selects
//  reg_gp_oe/we   out  1   GP read to bus / write from bus
//  reg_sel_pc/ir  out  1   system register selects
//  reg_sel_sys_hi/lo out 1 system byte selects
//  reg_sys_oe     out  1   system read to bus
//  reg_sys_we_hi/lo out 1  system byte writes
//  bank_af, bank_exx out 1 alternate-bank flags; swap_dehl out 2 DE/HL swap flag per EXX bank
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, req_ready=1, flags bank_af=bank_exx=0, swap_dehl=00.
//    Reset mid-op aborts: selects drop in the cycle after the reset edge; no done/err.
//  - Handshake: accept on rising edge with req_valid&req_ready; req_ready=0 until back in IDLE.
//    Request fields are captured at acceptance; later changes are ignored.
//  - States: IDLE -> RD | WR | XF1 | EXC. XF1 -> XF2. RD/WR/XF2/EXC -> IDLE.
//  - Outputs are registered: they are asserted in the cycle after acceptance.
//  - READ (RD, 1 cyc): select src, byte sels per req_hi/lo, oe of its class (gp or sys); done.
//  - WRITE (WR, 1 cyc): select dst. GP: reg_gp_we. Sys: reg_sys_we_hi/lo per byte enables. done.
//  - XFER:
//    - XF1: src selected + oe.
//    - XF2: src oe held; dst selected + we; done.
//    - Total 2 cycles. src==dst is legal and is rewritten unchanged.
//  - EX_AF/EXX/EX_DEHL (EXC, 1 cyc): no selects asserted; done.
//    - EX_AF toggles bank_af. EXX toggles bank_exx.
//    - EX_DEHL toggles swap_dehl[bank_exx].
//    - New mapping is used by the next accepted op.
//  - Mapping, applied at acceptance:
//    - AF -> af2 if bank_af, else af.
//    - BC -> bc2 if bank_exx, else bc.
//    - DE/HL -> per bank; exchanged when swap_dehl[bank_exx]=1.
//    - SP, IX, IY, WZ, PC, IR map directly.
//  - Invalid id or req_hi=req_lo=0 on READ/WRITE/XFER: 1-cycle op, no selects, done+err.
//  - NOP/op 7: 1-cycle op (EXC path, no flag change), done.
//  - Min op issue interval 2 cycles (accept, execute); XFER 3.
// CONFIGURATION
//  REG_CTL_IXIY_EN defined: ids 5/6 map to ix/iy.
//  Undefined: ids 5/6 are invalid (done+err); reg_sel_gp[ix], reg_sel_gp[iy] tied 0.
// STRUCTURE
//  reg_ctl_pkg: reg_id_t, reg_op_t, state_t enums; GP_* one-hot index constants; sys/gp class fn.
//  Sub-module reg_sel_decode (combinational): logical id + bank flags -> one-hot gp/sys select.
//  Instantiated for src and dst.
// TESTING
//  1. reset; WRITE dst=AF hi+lo -> next cycle reg_sel_gp=af, reg_gp_we=1, gp_hi/lo=1, done=1.
//  2. EX_AF then READ src=AF -> reg_sel_gp=af2, reg_gp_oe=1; bank_af=1.
//  3. EXX; EX_DEHL; READ src=DE -> hl2 selected; EXX; READ DE -> de (swap_dehl=10).
//  4. XFER src=PC lo-only, dst=WZ:
//     - XF1: reg_sel_pc, sys_lo, sys_oe.
//     - XF2: same + reg_sel_gp=wz, gp_we.
//     - done in XF2; req_ready back 1 cycle later.
//  5. READ src=12 -> done+err, all selects 0; without REG_CTL_IXIY_EN, src=IX -> done+err.
//  6. reset asserted during XF1 -> next cycle all outputs 0, no done, flags 0, req_ready=1.

Source files
------------

// File: rtl/reg_ctl_pkg.sv
// Shared types and constants for the register control unit: logical ids, ops, FSM states,
// one-hot physical GP select masks (bit 0 = af ... bit 11 = sp) and the decoded-select record.
package reg_ctl_pkg;

    typedef enum logic [3:0] {
        ID_BC = 4'd0,
        ID_DE = 4'd1,
        ID_HL = 4'd2,
        ID_AF = 4'd3,
        ID_SP = 4'd4,
        ID_IX = 4'd5,
        ID_IY = 4'd6,
        ID_WZ = 4'd7,
        ID_PC = 4'd8,
        ID_IR = 4'd9
    } reg_id_t;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_READ    = 3'd1,
        OP_WRITE   = 3'd2,
        OP_XFER    = 3'd3,
        OP_EX_AF   = 3'd4,
        OP_EXX     = 3'd5,
        OP_EX_DEHL = 3'd6,
        OP_RSVD    = 3'd7
    } reg_op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_XF1  = 3'd3,
        S_XF2  = 3'd4,
        S_EXC  = 3'd5
    } state_t;

    localparam int GP_W = 12;

    localparam logic [GP_W-1:0] GP_AF  = 12'h001;
    localparam logic [GP_W-1:0] GP_AF2 = 12'h002;
    localparam logic [GP_W-1:0] GP_BC  = 12'h004;
    localparam logic [GP_W-1:0] GP_BC2 = 12'h008;
    localparam logic [GP_W-1:0] GP_DE  = 12'h010;
    localparam logic [GP_W-1:0] GP_DE2 = 12'h020;
    localparam logic [GP_W-1:0] GP_HL  = 12'h040;
    localparam logic [GP_W-1:0] GP_HL2 = 12'h080;
    localparam logic [GP_W-1:0] GP_IX  = 12'h100;
    localparam logic [GP_W-1:0] GP_IY  = 12'h200;
    localparam logic [GP_W-1:0] GP_WZ  = 12'h400;
    localparam logic [GP_W-1:0] GP_SP  = 12'h800;

    typedef struct packed {
        logic [GP_W-1:0] gp;
        logic            pc;
        logic            ir;
        logic            ok;
    } sel_t;

    function automatic logic is_sys(input logic [3:0] id);
        return (id == ID_PC) || (id == ID_IR);
    endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// Logical register id + bank flags -> one-hot physical select; purely combinational.
// IX/IY decode only when REG_CTL_IXIY_EN is defined, otherwise they report not-ok.
module reg_sel_decode
    import reg_ctl_pkg::*;
(
    input  logic [3:0] id,
    input  logic       bank_af,
    input  logic       bank_exx,
    input  logic [1:0] swap_dehl,
    output sel_t       sel
);

    logic swapped;
    assign swapped = swap_dehl[bank_exx];

    always_comb begin
        sel    = '0;
        sel.ok = 1'b1;
        case (id)
            ID_AF: sel.gp = bank_af  ? GP_AF2 : GP_AF;
            ID_BC: sel.gp = bank_exx ? GP_BC2 : GP_BC;
            // DE and HL trade places inside the active EXX bank when its swap flag is set
            ID_DE: sel.gp = swapped ? (bank_exx ? GP_HL2 : GP_HL)
                                    : (bank_exx ? GP_DE2 : GP_DE);
            ID_HL: sel.gp = swapped ? (bank_exx ? GP_DE2 : GP_DE)
                                    : (bank_exx ? GP_HL2 : GP_HL);
            ID_SP: sel.gp = GP_SP;
            ID_WZ: sel.gp = GP_WZ;
`ifdef REG_CTL_IXIY_EN
            ID_IX: sel.gp = GP_IX;
            ID_IY: sel.gp = GP_IY;
`endif
            ID_PC: sel.pc = 1'b1;
            ID_IR: sel.ir = 1'b1;
            default: sel.ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_control.sv
// Register-file control FSM: one op at a time, outputs valid the cycle after acceptance,
// req_ready low until back in IDLE (1 busy cycle, 2 for XFER). Option macro: REG_CTL_IXIY_EN.
module reg_control
    import reg_ctl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_src,
    input  logic [3:0]  req_dst,
    input  logic        req_hi,
    input  logic        req_lo,
    output logic        done,
    output logic        err,
    output logic [11:0] reg_sel_gp,
    output logic        reg_sel_gp_hi,
    output logic        reg_sel_gp_lo,
    output logic        reg_gp_oe,
    output logic        reg_gp_we,
    output logic        reg_sel_pc,
    output logic        reg_sel_ir,
    output logic        reg_sel_sys_hi,
    output logic        reg_sel_sys_lo,
    output logic        reg_sys_oe,
    output logic        reg_sys_we_hi,
    output logic        reg_sys_we_lo,
    output logic        bank_af,
    output logic        bank_exx,
    output logic [1:0]  swap_dehl
);

    state_t          state, state_nxt;
    sel_t            src_dec, dst_dec;
    logic [GP_W-1:0] src_gp_q, dst_gp_q;
    logic            src_pc_q, src_ir_q, dst_pc_q, dst_ir_q;
    logic            hi_q, lo_q, err_q;
    logic            accept, req_bad, no_bytes;
    logic            rd_src, wr_dst, src_sys, dst_sys;

    reg_sel_decode u_src_dec (
        .id        (req_src),
        .bank_af   (bank_af),
        .bank_exx  (bank_exx),
        .swap_dehl (swap_dehl),
        .sel       (src_dec)
    );

    reg_sel_decode u_dst_dec (
        .id        (req_dst),
        .bank_af   (bank_af),
        .bank_exx  (bank_exx),
        .swap_dehl (swap_dehl),
        .sel       (dst_dec)
    );

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign no_bytes  = !req_hi && !req_lo;

    always_comb begin
        req_bad = 1'b0;
        case (req_op)
            OP_READ:  req_bad = !src_dec.ok || no_bytes;
            OP_WRITE: req_bad = !dst_dec.ok || no_bytes;
            OP_XFER:  req_bad = !src_dec.ok || !dst_dec.ok || no_bytes;
            default:  req_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_nxt = S_EXC;
                    end else begin
                        case (req_op)
                            OP_READ:  state_nxt = S_RD;
                            OP_WRITE: state_nxt = S_WR;
                            OP_XFER:  state_nxt = S_XF1;
                            default:  state_nxt = S_EXC;
                        endcase
                    end
                end
            end
            S_XF1:   state_nxt = S_XF2;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture; bank flags flip at acceptance so the next op sees the new mapping
    always_ff @(posedge clk) begin
        if (reset) begin
            src_gp_q  <= '0;
            dst_gp_q  <= '0;
            src_pc_q  <= 1'b0;
            src_ir_q  <= 1'b0;
            dst_pc_q  <= 1'b0;
            dst_ir_q  <= 1'b0;
            hi_q      <= 1'b0;
            lo_q      <= 1'b0;
            err_q     <= 1'b0;
            bank_af   <= 1'b0;
            bank_exx  <= 1'b0;
            swap_dehl <= 2'b00;
        end else if (accept) begin
            src_gp_q <= src_dec.gp;
            src_pc_q <= src_dec.pc;
            src_ir_q <= src_dec.ir;
            dst_gp_q <= dst_dec.gp;
            dst_pc_q <= dst_dec.pc;
            dst_ir_q <= dst_dec.ir;
            hi_q     <= req_hi;
            lo_q     <= req_lo;
            err_q    <= req_bad;
            case (req_op)
                OP_EX_AF:   bank_af  <= !bank_af;
                OP_EXX:     bank_exx <= !bank_exx;
                OP_EX_DEHL: swap_dehl[bank_exx] <= !swap_dehl[bank_exx];
                default: ;
            endcase
        end
    end

    assign src_sys = src_pc_q || src_ir_q;
    assign dst_sys = dst_pc_q || dst_ir_q;

    always_comb begin
        rd_src = (state == S_RD) || (state == S_XF1) || (state == S_XF2);
        wr_dst = (state == S_WR) || (state == S_XF2);

        done = (state == S_RD) || (state == S_WR) || (state == S_XF2) || (state == S_EXC);
        err  = (state == S_EXC) && err_q;

        reg_sel_gp = (rd_src ? src_gp_q : '0) | (wr_dst ? dst_gp_q : '0);
        reg_sel_pc = (rd_src && src_pc_q) || (wr_dst && dst_pc_q);
        reg_sel_ir = (rd_src && src_ir_q) || (wr_dst && dst_ir_q);

        reg_gp_oe  = rd_src && !src_sys;
        reg_sys_oe = rd_src && src_sys;
        reg_gp_we  = wr_dst && !dst_sys;

        reg_sel_gp_hi  = ((rd_src && !src_sys) || (wr_dst && !dst_sys)) && hi_q;
        reg_sel_gp_lo  = ((rd_src && !src_sys) || (wr_dst && !dst_sys)) && lo_q;
        reg_sel_sys_hi = ((rd_src && src_sys) || (wr_dst && dst_sys)) && hi_q;
        reg_sel_sys_lo = ((rd_src && src_sys) || (wr_dst && dst_sys)) && lo_q;
        reg_sys_we_hi  = wr_dst && dst_sys && hi_q;
        reg_sys_we_lo  = wr_dst && dst_sys && lo_q;
    end

endmodule

// File: tb/tb_reg_control.sv
// Scoreboard bench for reg_control: a driver pushes the expected per-cycle outputs of each op,
// a negedge monitor pops one entry per busy cycle and checks idle cycles against the model.
module tb_reg_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [3:0]  req_src;
    logic [3:0]  req_dst;
    logic        req_hi;
    logic        req_lo;
    logic        done;
    logic        err;
    logic [11:0] reg_sel_gp;
    logic        reg_sel_gp_hi;
    logic        reg_sel_gp_lo;
    logic        reg_gp_oe;
    logic        reg_gp_we;
    logic        reg_sel_pc;
    logic        reg_sel_ir;
    logic        reg_sel_sys_hi;
    logic        reg_sel_sys_lo;
    logic        reg_sys_oe;
    logic        reg_sys_we_hi;
    logic        reg_sys_we_lo;
    logic        bank_af;
    logic        bank_exx;
    logic [1:0]  swap_dehl;

    always #5 clk = !clk;

    reg_control dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_src        (req_src),
        .req_dst        (req_dst),
        .req_hi         (req_hi),
        .req_lo         (req_lo),
        .done           (done),
        .err            (err),
        .reg_sel_gp     (reg_sel_gp),
        .reg_sel_gp_hi  (reg_sel_gp_hi),
        .reg_sel_gp_lo  (reg_sel_gp_lo),
        .reg_gp_oe      (reg_gp_oe),
        .reg_gp_we      (reg_gp_we),
        .reg_sel_pc     (reg_sel_pc),
        .reg_sel_ir     (reg_sel_ir),
        .reg_sel_sys_hi (reg_sel_sys_hi),
        .reg_sel_sys_lo (reg_sel_sys_lo),
        .reg_sys_oe     (reg_sys_oe),
        .reg_sys_we_hi  (reg_sys_we_hi),
        .reg_sys_we_lo  (reg_sys_we_lo),
        .bank_af        (bank_af),
        .bank_exx       (bank_exx),
        .swap_dehl      (swap_dehl)
    );

    typedef struct packed {
        logic        done;
        logic        err;
        logic [11:0] gp;
        logic        gp_hi;
        logic        gp_lo;
        logic        gp_oe;
        logic        gp_we;
        logic        pc;
        logic        ir;
        logic        sys_hi;
        logic        sys_lo;
        logic        sys_oe;
        logic        sys_we_hi;
        logic        sys_we_lo;
        logic        bank_af;
        logic        bank_exx;
        logic [1:0]  swap;
    } obs_t;

    obs_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    // Reference state: the alternate-bank flags as the programmer sees them
    bit       m_af   = 1'b0;
    bit       m_exx  = 1'b0;
    bit [1:0] m_swap = 2'b00;

    localparam int P_PC = 100;
    localparam int P_IR = 101;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Physical GP bit (0=af,1=af2,2=bc,3=bc2,4=de,5=de2,6=hl,7=hl2,8=ix,9=iy,10=wz,11=sp),
    // P_PC/P_IR for system registers, -1 when the id is not usable.
    function automatic int phys(input int id);
        bit hl_side;
        case (id)
            0: return m_exx ? 3 : 2;
            3: return m_af ? 1 : 0;
            1, 2: begin
                hl_side = (id == 2) ^ m_swap[m_exx];
                return (hl_side ? 6 : 4) + (m_exx ? 1 : 0);
            end
            4: return 11;
            7: return 10;
            8: return P_PC;
            9: return P_IR;
`ifdef REG_CTL_IXIY_EN
            5: return 8;
            6: return 9;
`endif
            default: return -1;
        endcase
    endfunction

    function automatic obs_t add_rd(input obs_t e, input int p, input bit hi, input bit lo);
        obs_t r = e;
        if (p >= P_PC) begin
            if (p == P_PC) r.pc = 1'b1; else r.ir = 1'b1;
            r.sys_hi = r.sys_hi | hi;
            r.sys_lo = r.sys_lo | lo;
            r.sys_oe = 1'b1;
        end else begin
            r.gp[p]  = 1'b1;
            r.gp_hi  = r.gp_hi | hi;
            r.gp_lo  = r.gp_lo | lo;
            r.gp_oe  = 1'b1;
        end
        return r;
    endfunction

    function automatic obs_t add_wr(input obs_t e, input int p, input bit hi, input bit lo);
        obs_t r = e;
        if (p >= P_PC) begin
            if (p == P_PC) r.pc = 1'b1; else r.ir = 1'b1;
            r.sys_hi    = r.sys_hi | hi;
            r.sys_lo    = r.sys_lo | lo;
            r.sys_we_hi = hi;
            r.sys_we_lo = lo;
        end else begin
            r.gp[p] = 1'b1;
            r.gp_hi = r.gp_hi | hi;
            r.gp_lo = r.gp_lo | lo;
            r.gp_we = 1'b1;
        end
        return r;
    endfunction

    function automatic obs_t flags_only();
        obs_t r = '0;
        r.bank_af  = m_af;
        r.bank_exx = m_exx;
        r.swap     = m_swap;
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t r;
        r.done      = done;
        r.err       = err;
        r.gp        = reg_sel_gp;
        r.gp_hi     = reg_sel_gp_hi;
        r.gp_lo     = reg_sel_gp_lo;
        r.gp_oe     = reg_gp_oe;
        r.gp_we     = reg_gp_we;
        r.pc        = reg_sel_pc;
        r.ir        = reg_sel_ir;
        r.sys_hi    = reg_sel_sys_hi;
        r.sys_lo    = reg_sel_sys_lo;
        r.sys_oe    = reg_sys_oe;
        r.sys_we_hi = reg_sys_we_hi;
        r.sys_we_lo = reg_sys_we_lo;
        r.bank_af   = bank_af;
        r.bank_exx  = bank_exx;
        r.swap      = swap_dehl;
        return r;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", {31'b0, req_ready}, 32'd1);
    endtask

    // Issue one op; after the accepting edge push the expected output of every busy cycle
    task automatic issue(input int op, input int src, input int dst, input bit hi, input bit lo);
        int   ps, pd;
        bit   is_bad;
        obs_t base, e1, e2;
        wait_idle();
        req_valid = 1'b1;
        req_op    = 3'(op);
        req_src   = 4'(src);
        req_dst   = 4'(dst);
        req_hi    = hi;
        req_lo    = lo;
        ps = phys(src);
        pd = phys(dst);
        case (op)
            1:       is_bad = (ps < 0) || (!hi && !lo);
            2:       is_bad = (pd < 0) || (!hi && !lo);
            3:       is_bad = (ps < 0) || (pd < 0) || (!hi && !lo);
            default: is_bad = 1'b0;
        endcase
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_src   = 4'($urandom);
        req_dst   = 4'($urandom);
        req_hi    = 1'($urandom);
        req_lo    = 1'($urandom);
        if (op == 4) m_af = !m_af;
        if (op == 5) m_exx = !m_exx;
        if (op == 6) m_swap[m_exx] = !m_swap[m_exx];
        base = flags_only();
        if (is_bad) begin
            e1 = base;
            e1.done = 1'b1;
            e1.err  = 1'b1;
            sb.push_back(e1);
        end else if (op == 1) begin
            e1 = add_rd(base, ps, hi, lo);
            e1.done = 1'b1;
            sb.push_back(e1);
        end else if (op == 2) begin
            e1 = add_wr(base, pd, hi, lo);
            e1.done = 1'b1;
            sb.push_back(e1);
        end else if (op == 3) begin
            e1 = add_rd(base, ps, hi, lo);
            e2 = add_wr(e1, pd, hi, lo);
            e2.done = 1'b1;
            sb.push_back(e1);
            sb.push_back(e2);
        end else begin
            e1 = base;
            e1.done = 1'b1;
            sb.push_back(e1);
        end
    endtask

    obs_t mon_act, mon_exp;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = sample();
            if (!req_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL busy_unexpected: got outputs %h while no cycle expected", mon_act);
                end else begin
                    mon_exp = sb.pop_front();
                    check("busy_cycle", {3'b0, mon_act}, {3'b0, mon_exp});
                end
            end else begin
                check("idle_pending", 32'(sb.size()), 32'd0);
                sb.delete();
                check("idle_outputs", {3'b0, mon_act}, {3'b0, flags_only()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_src   = '0;
        req_dst   = '0;
        req_hi    = 1'b0;
        req_lo    = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'b0, req_ready}, 32'd1);

        // Directed scenarios
        issue(2, 3, 3, 1, 1);
        issue(4, 0, 0, 0, 0);
        issue(1, 3, 0, 1, 1);
        wait_idle();
        check("bank_af_set", {31'b0, bank_af}, 32'd1);
        issue(5, 0, 0, 0, 0);
        issue(6, 0, 0, 0, 0);
        issue(1, 1, 0, 1, 1);
        issue(5, 0, 0, 0, 0);
        issue(1, 1, 0, 1, 1);
        wait_idle();
        check("swap_dehl_10", {30'b0, swap_dehl}, 32'd2);
        check("bank_exx_back", {31'b0, bank_exx}, 32'd0);
        issue(3, 8, 7, 0, 1);
        issue(1, 12, 0, 1, 1);
        issue(1, 5, 0, 1, 1);
        issue(2, 6, 6, 1, 0);
        issue(1, 0, 0, 0, 0);
        issue(3, 2, 2, 1, 0);
        issue(3, 9, 8, 1, 1);
        issue(2, 15, 0, 1, 1);
        issue(0, 0, 0, 1, 1);
        issue(7, 0, 0, 1, 1);

        // Reset during XF1: the second XFER cycle must never appear
        issue(3, 0, 1, 1, 1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        m_af   = 1'b0;
        m_exx  = 1'b0;
        m_swap = 2'b00;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_done", {31'b0, done}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int op, s, d;
            bit h, l;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = $urandom_range(0, 7);
            s  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            d  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            h  = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 3) != 0);
            issue(op, s, d, h, l);
        end
        wait_idle();
        @(negedge clk);
        check("final_queue", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
